// File: rtl/apb_reg_map_pkg.sv
// Shared definitions for the APB register map: widths, register addresses,
// the transfer state encoding and the byte-lane merge helper.
package apb_reg_map_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 20;
    localparam int NUM_KEYS = 6;
    localparam int CNT_W    = 3;

    localparam logic [ADDR_W-1:0] ADDR_CTRL   = 20'h00000;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 20'h00002;
    localparam logic [ADDR_W-1:0] ADDR_KEY0   = 20'h00004;
    localparam logic [ADDR_W-1:0] ADDR_KEY5   = 20'h0000E;
    localparam logic [ADDR_W-1:0] ADDR_ID     = 20'h00010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        SEL_NONE   = 3'd0,
        SEL_CTRL   = 3'd1,
        SEL_STATUS = 3'd2,
        SEL_KEY    = 3'd3,
        SEL_ID     = 3'd4
    } sel_e;

    function automatic logic [DATA_W-1:0] apply_strobe(
        input logic [DATA_W-1:0] old_val,
        input logic [DATA_W-1:0] new_val,
        input logic [1:0]        strb
    );
        logic [DATA_W-1:0] res;
        res       = old_val;
        if (strb[0]) res[7:0]  = new_val[7:0];
        if (strb[1]) res[15:8] = new_val[15:8];
        return res;
    endfunction

endpackage

// File: rtl/apb_reg_map.sv
// APB completer exposing CTRL, STATUS, a 96-bit key bank and an ID register,
// with a programmable number of wait states before the registered response.
module apb_reg_map
    import apb_reg_map_pkg::*;
#(
    parameter int              WAIT_STATES = 1,
    parameter logic [15:0]     ID_VALUE    = 16'hC0DE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [1:0]            pstrb,
    input  logic [ADDR_W-1:0]     paddr,
    input  logic [DATA_W-1:0]     pwdata,
    output logic [DATA_W-1:0]     prdata,
    output logic                  pready,
    output logic                  pslverr,
    input  logic [DATA_W-1:0]     status_i,
    output logic [DATA_W-1:0]     ctrl_o,
    output logic [NUM_KEYS*DATA_W-1:0] key_o,
    output logic                  key_load_o
);

    state_e            state;
    logic [CNT_W-1:0]  wait_cnt;
    logic [DATA_W-1:0] ctrl_q;
    logic [DATA_W-1:0] key_q [NUM_KEYS];

    sel_e              sel;
    logic [2:0]        key_idx;
    logic              acc_err;
    logic [DATA_W-1:0] rdata_mux;

    // Address decode; odd byte addresses never hit a register
    always_comb begin
        sel     = SEL_NONE;
        key_idx = paddr[3:1] - 3'd2;
        if (!paddr[0]) begin
            if (paddr == ADDR_CTRL)
                sel = SEL_CTRL;
            else if (paddr == ADDR_STATUS)
                sel = SEL_STATUS;
            else if (paddr >= ADDR_KEY0 && paddr <= ADDR_KEY5)
                sel = SEL_KEY;
            else if (paddr == ADDR_ID)
                sel = SEL_ID;
        end
        acc_err = (sel == SEL_NONE) ||
                  (pwrite && (sel == SEL_STATUS || sel == SEL_ID));
    end

    always_comb begin
        rdata_mux = '0;
        case (sel)
            SEL_CTRL:   rdata_mux = ctrl_q;
            SEL_STATUS: rdata_mux = status_i;
            SEL_KEY:    rdata_mux = key_q[key_idx];
            SEL_ID:     rdata_mux = ID_VALUE;
            default:    rdata_mux = '0;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_KEYS; i++)
            key_o[i*DATA_W +: DATA_W] = key_q[i];
    end

    assign ctrl_o = ctrl_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            prdata     <= '0;
            pready     <= 1'b0;
            pslverr    <= 1'b0;
            ctrl_q     <= '0;
            key_load_o <= 1'b0;
            for (int i = 0; i < NUM_KEYS; i++)
                key_q[i] <= '0;
        end else begin
            key_load_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (psel && !penable) begin
                        state    <= ST_ACCESS;
                        wait_cnt <= CNT_W'(WAIT_STATES);
                    end
                end
                ST_ACCESS: begin
                    if (!psel) begin
                        state    <= ST_IDLE;
                        wait_cnt <= '0;
                    end else if (penable) begin
                        if (wait_cnt != '0) begin
                            wait_cnt <= wait_cnt - 1'b1;
                        end else begin
                            state   <= ST_RESP;
                            pready  <= 1'b1;
                            pslverr <= acc_err;
                            if (!pwrite)
                                prdata <= acc_err ? '0 : rdata_mux;
                            // Writes commit on the same edge that raises pready
                            if (pwrite && !acc_err && pstrb != 2'b00) begin
                                if (sel == SEL_CTRL)
                                    ctrl_q <= apply_strobe(ctrl_q, pwdata, pstrb);
                                if (sel == SEL_KEY) begin
                                    for (int i = 0; i < NUM_KEYS; i++)
                                        if (key_idx == 3'(i))
                                            key_q[i] <= apply_strobe(key_q[i], pwdata, pstrb);
                                    key_load_o <= (key_idx == 3'(NUM_KEYS-1));
                                end
                            end
                        end
                    end
                end
                ST_RESP: begin
                    state   <= ST_IDLE;
                    pready  <= 1'b0;
                    pslverr <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_reg_map.sv
// Directed bench for apb_reg_map: one instance with one wait state and one
// with three, sharing the APB bus; each step checks against hand-derived values.
module tb_apb_reg_map;

    logic        clk = 1'b0;
    logic        reset;
    logic        psel, penable, pwrite;
    logic [1:0]  pstrb;
    logic [19:0] paddr;
    logic [15:0] pwdata;
    logic [15:0] status_i;

    logic [15:0] prdata1, prdata3, ctrl1, ctrl3;
    logic        pready1, pready3, pslverr1, pslverr3, kl1, kl3;
    logic [95:0] key1, key3;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    apb_reg_map #(.WAIT_STATES(1), .ID_VALUE(16'hC0DE)) u_dut1 (
        .clk(clk), .reset(reset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pstrb(pstrb), .paddr(paddr), .pwdata(pwdata), .prdata(prdata1),
        .pready(pready1), .pslverr(pslverr1), .status_i(status_i),
        .ctrl_o(ctrl1), .key_o(key1), .key_load_o(kl1)
    );

    apb_reg_map #(.WAIT_STATES(3), .ID_VALUE(16'hC0DE)) u_dut3 (
        .clk(clk), .reset(reset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pstrb(pstrb), .paddr(paddr), .pwdata(pwdata), .prdata(prdata3),
        .pready(pready3), .pslverr(pslverr3), .status_i(status_i),
        .ctrl_o(ctrl3), .key_o(key3), .key_load_o(kl3)
    );

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transfer aimed at either instance; returns data, error, key_load and latency
    task automatic xfer(input bit use3, input bit wr, input logic [19:0] a,
                        input logic [15:0] d, input logic [1:0] s,
                        output logic [15:0] rd, output logic err,
                        output logic kl, output int lat);
        logic rdy;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
        @(posedge clk); #1;
        penable = 1'b1;
        lat = 1;
        rdy = use3 ? pready3 : pready1;
        while (!rdy && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            rdy = use3 ? pready3 : pready1;
        end
        rd  = use3 ? prdata3  : prdata1;
        err = use3 ? pslverr3 : pslverr1;
        kl  = use3 ? kl3      : kl1;
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        check("pready_one_cycle", 96'(use3 ? pready3 : pready1), 96'd0);
    endtask

    logic [15:0] rd;
    logic        err, kl;
    int          lat;
    int          kl_seen;

    initial begin
        reset = 1'b1; psel = 0; penable = 0; pwrite = 0; pstrb = 2'b00;
        paddr = '0; pwdata = '0; status_i = 16'h5A3C;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pready",  96'(pready1),  96'd0);
        check("rst_prdata",  96'(prdata1),  96'd0);
        check("rst_pslverr", 96'(pslverr1), 96'd0);
        check("rst_ctrl",    96'(ctrl1),    96'd0);
        check("rst_key",     key1,          96'd0);
        check("rst_keyload", 96'(kl1),      96'd0);
        reset = 1'b0;

        // ID read, latency WAIT_STATES + 2
        xfer(0, 0, 20'h00010, 16'h0, 2'b00, rd, err, kl, lat);
        check("id_lat",  96'(lat), 96'd3);
        check("id_data", 96'(rd),  96'hC0DE);
        check("id_err",  96'(err), 96'd0);

        // Byte-lane writes to CTRL
        xfer(0, 1, 20'h00000, 16'hA5A5, 2'b01, rd, err, kl, lat);
        check("ctrl_w1_err", 96'(err), 96'd0);
        xfer(0, 0, 20'h00000, 16'h0, 2'b00, rd, err, kl, lat);
        check("ctrl_rd1", 96'(rd), 96'h00A5);
        xfer(0, 1, 20'h00000, 16'h1234, 2'b10, rd, err, kl, lat);
        xfer(0, 0, 20'h00000, 16'h0, 2'b00, rd, err, kl, lat);
        check("ctrl_rd2", 96'(rd),    96'h12A5);
        check("ctrl_o",   96'(ctrl1), 96'h12A5);

        // Empty strobe is a silent no-op
        xfer(0, 1, 20'h00000, 16'hFFFF, 2'b00, rd, err, kl, lat);
        check("strb0_err",  96'(err),   96'd0);
        check("strb0_ctrl", 96'(ctrl1), 96'h12A5);

        // Error cases
        xfer(0, 1, 20'h00010, 16'hFFFF, 2'b11, rd, err, kl, lat);
        check("wr_id_err", 96'(err), 96'd1);
        xfer(0, 1, 20'h00003, 16'hFFFF, 2'b11, rd, err, kl, lat);
        check("wr_odd_err", 96'(err), 96'd1);
        xfer(0, 1, 20'h00100, 16'hFFFF, 2'b11, rd, err, kl, lat);
        check("wr_unmap_err", 96'(err), 96'd1);
        check("err_ctrl_kept", 96'(ctrl1), 96'h12A5);
        xfer(0, 1, 20'h00002, 16'hFFFF, 2'b11, rd, err, kl, lat);
        check("wr_status_err", 96'(err), 96'd1);
        xfer(0, 0, 20'h00010, 16'h0, 2'b00, rd, err, kl, lat);
        check("id_after_err", 96'(rd), 96'hC0DE);
        check("id_after_err_e", 96'(err), 96'd0);
        xfer(0, 0, 20'h00100, 16'h0, 2'b00, rd, err, kl, lat);
        check("rd_unmap_err",  96'(err), 96'd1);
        check("rd_unmap_data", 96'(rd),  96'h0000);

        // STATUS reflects the live input
        xfer(0, 0, 20'h00002, 16'h0, 2'b00, rd, err, kl, lat);
        check("status_rd", 96'(rd), 96'h5A3C);

        // Key bank
        for (int i = 0; i < 6; i++) begin
            xfer(0, 1, 20'h00004 + 20'(2*i), 16'(i+1), 2'b11, rd, err, kl, lat);
            check("key_wr_err", 96'(err), 96'd0);
            check("key_load",   96'(kl),  (i == 5) ? 96'd1 : 96'd0);
        end
        check("key_o", key1, 96'h0006_0005_0004_0003_0002_0001);
        xfer(0, 0, 20'h0000A, 16'h0, 2'b00, rd, err, kl, lat);
        check("key3_rd", 96'(rd), 96'h0004);
        xfer(0, 1, 20'h0000E, 16'h7777, 2'b00, rd, err, kl, lat);
        check("key5_strb0_kl", 96'(kl), 96'd0);

        // Three-wait-state instance: normal write then aborted write
        xfer(1, 1, 20'h00000, 16'h0F0F, 2'b11, rd, err, kl, lat);
        check("ws3_lat",  96'(lat),   96'd5);
        check("ws3_ctrl", 96'(ctrl3), 96'h0F0F);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 20'h00000;
        pwdata = 16'h1111; pstrb = 2'b11;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        kl_seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (pready3) kl_seen++;
        end
        check("abort_no_pready", 96'(kl_seen), 96'd0);
        check("abort_ctrl",      96'(ctrl3),   96'h0F0F);

        // Reset in the middle of a KEY5 write
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 20'h0000E;
        pwdata = 16'hBEEF; pstrb = 2'b11;
        @(posedge clk); #1;
        penable = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        kl_seen = 0;
        check("midrst_key",    key1,         96'd0);
        check("midrst_pready", 96'(pready1), 96'd0);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (kl1 || pready1) kl_seen++;
        end
        psel = 1'b0; penable = 1'b0;
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (kl1 || pready1) kl_seen++;
        end
        check("midrst_no_kl", 96'(kl_seen), 96'd0);
        check("midrst_key5",  96'(key1[95:80]), 96'd0);
        xfer(0, 0, 20'h00010, 16'h0, 2'b00, rd, err, kl, lat);
        check("post_rst_lat", 96'(lat), 96'd3);
        check("post_rst_id",  96'(rd),  96'hC0DE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
